// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM states, fine-code limit and event word field positions for the TDC readout
package tdc_pkg;
    typedef enum logic [2:0] {IDLE, SEL, CAPT, OUT, ACK} state_t;
    localparam logic [7:0] FINE_MAX    = 8'h27;
    localparam int         OD_FINE_LSB = 24;
    localparam int         OD_ERR_BIT  = 23;
    localparam int         OD_CH_LSB   = 16;
    function automatic logic fine_err(input logic [7:0] f);
        return (f == 8'h00) || (f > FINE_MAX);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after the last granted index
//   req     : request vector
//   last    : index granted last time; search starts at last+1, wrapping N-1 -> 0
//   gnt     : granted index, valid when gnt_vld
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt,
    output logic          gnt_vld
);
    always_comb begin
        logic [IW-1:0] idx;
        idx     = '0;
        gnt     = '0;
        gnt_vld = 1'b0;
        // walk from the farthest candidate down so the nearest one after last wins
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k >= N) ? int'(last) + k - N : int'(last) + k);
            if (req[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdc_readout_sched.sv
// tdc_readout_sched: stamps TDC hits and reads the shared encoder bus one channel at a time
//   hit_vld/hit_ack : per-channel latched-hit flag and one-cycle clear pulse
//   enc_sel_n       : active-low encoder enables, at most one low, only in SEL/CAPT
//   enc_data        : shared fine-code bus
//   out_vld/out_rdy/out_data : event word {fine, err, channel, stamp} with ready/valid handshake
module tdc_readout_sched
    import tdc_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] hit_vld,
    output logic [NCH-1:0] hit_ack,
    output logic [NCH-1:0] enc_sel_n,
    input  logic [7:0]     enc_data,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [31:0]    out_data
);
    localparam int IW = $clog2(NCH);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NCH-1:0]          prev_q;
    logic [NCH-1:0][CW-1:0]  stamp_q, stamp_d;
    logic [IW-1:0]           grant_q, grant_d, arb_gnt;
    logic                    arb_vld;
    logic [NCH-1:0]          hit_ack_q, hit_ack_d, enc_sel_n_q, enc_sel_n_d, onehot;
    logic                    out_vld_q, out_vld_d;
    logic [31:0]             out_data_q, out_data_d;
    logic [15:0]             stamp16;

    // only channels whose stamp was captured on an earlier edge may request
    rr_arbiter #(.N(NCH), .IW(IW)) u_arb (
        .req     (hit_vld & prev_q),
        .last    (grant_q),
        .gnt     (arb_gnt),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        cnt_d      = cnt_q + CW'(1);
        stamp_d    = stamp_q;
        for (int i = 0; i < NCH; i++)
            stamp_d[i] = (hit_vld[i] && !prev_q[i]) ? cnt_q : stamp_q[i];
        state_d    = state_q;
        grant_d    = grant_q;
        out_data_d = out_data_q;
        stamp16    = 16'(stamp_q[grant_q]);
        case (state_q)
            IDLE: if (arb_vld) begin
                state_d = SEL;
                grant_d = arb_gnt;
            end
            SEL:  state_d = CAPT;
            CAPT: begin
                state_d                       = OUT;
                out_data_d                    = '0;
                out_data_d[OD_FINE_LSB +: 8]  = enc_data;
                out_data_d[OD_ERR_BIT]        = fine_err(enc_data);
                out_data_d[OD_CH_LSB +: 7]    = 7'(grant_q);
                out_data_d[15:0]              = stamp16;
            end
            OUT:  state_d = out_rdy ? ACK : OUT;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        onehot      = NCH'(1) << grant_d;
        hit_ack_d   = (state_d == ACK) ? onehot : '0;
        enc_sel_n_d = (state_d == SEL || state_d == CAPT) ? ~onehot : '1;
        out_vld_d   = (state_d == OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_q      <= '0;
            stamp_q     <= '0;
            grant_q     <= IW'(NCH - 1);
            hit_ack_q   <= '0;
            enc_sel_n_q <= '1;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= hit_vld;
            stamp_q     <= stamp_d;
            grant_q     <= grant_d;
            hit_ack_q   <= hit_ack_d;
            enc_sel_n_q <= enc_sel_n_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
        end
    end

    assign hit_ack   = hit_ack_q;
    assign enc_sel_n = enc_sel_n_q;
    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_tdc_readout_sched.sv
// tb_tdc_readout_sched: vector table plus corner sequences with an event-word scoreboard
module tb_tdc_readout_sched;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] hit_vld, hit_ack, enc_sel_n;
    logic [7:0]     enc_data;
    logic           out_vld, out_rdy;
    logic [31:0]    out_data;

    tdc_readout_sched #(.NCH(NCH), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .hit_vld   (hit_vld),
        .hit_ack   (hit_ack),
        .enc_sel_n (enc_sel_n),
        .enc_data  (enc_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [7:0] fine;
        logic       err;
        int         at;
    } vec_t;

    int             checks, errors;
    logic [31:0]    sbq[$];
    logic [15:0]    mcnt;
    logic [7:0]     fine_tab [NCH];
    logic [NCH-1:0] prev_ack, prev_sel_n, ack_seen;
    vec_t           tbl [7];

    function automatic logic [31:0] mkw(input int ch, input logic [7:0] f, input logic e, input logic [15:0] s);
        return {f, e, 7'(ch), s};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] e;
        logic gapv;
        if (out_vld && out_rdy) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", out_data);
            end else begin
                e = sbq.pop_front();
                chk("event_word", out_data, e);
            end
        end
        @(posedge clk);
        mcnt = rst ? 16'h0 : mcnt + 16'h1;
        @(negedge clk);
        chk("sel_multi_low", 32'($countones(~enc_sel_n) > 1), 0);
        gapv = (prev_sel_n != '1) && (enc_sel_n != '1) && (prev_sel_n != enc_sel_n);
        chk("sel_no_gap", 32'(gapv), 0);
        if (hit_ack != '0) begin
            chk("ack_onehot", $countones(hit_ack), 1);
            chk("ack_single_pulse", 32'(prev_ack), 0);
            hit_vld  = hit_vld & ~hit_ack;
            ack_seen = ack_seen | hit_ack;
        end
        prev_ack   = hit_ack;
        prev_sel_n = enc_sel_n;
        enc_data   = 8'h00;
        for (int i = 0; i < NCH; i++)
            if (!enc_sel_n[i]) enc_data = fine_tab[i];
    endtask

    task automatic wait_acks(input logic [NCH-1:0] mask, input int budget, input string name);
        int n;
        n = 0;
        while ((ack_seen & mask) != mask && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'((ack_seen & mask) == mask), 1);
    endtask

    task automatic wait_cnt(input logic [15:0] v);
        int n;
        n = 0;
        while (mcnt != v && n < 70000) begin
            tick();
            n++;
        end
        chk("coarse_reached", 32'(mcnt), 32'(v));
    endtask

    task automatic run_one(input vec_t v);
        int vat, aat;
        if (v.at >= 0) wait_cnt(16'(v.at));
        fine_tab[v.ch] = v.fine;
        ack_seen = '0;
        sbq.push_back(mkw(v.ch, v.fine, v.err, mcnt));
        hit_vld[v.ch] = 1'b1;
        vat = 0;
        aat = 0;
        for (int n = 1; n <= 20 && aat == 0; n++) begin
            tick();
            if (out_vld && vat == 0) vat = n;
            if (hit_ack[v.ch]) aat = n;
        end
        chk("latency_out_vld", vat, 4);
        chk("latency_ack", aat, 5);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] held;
        int n;
        tbl[0] = '{2, 8'h13, 1'b0, 256};
        tbl[1] = '{0, 8'h00, 1'b1, -1};
        tbl[2] = '{1, 8'h30, 1'b1, -1};
        tbl[3] = '{3, 8'h27, 1'b0, -1};
        tbl[4] = '{0, 8'h01, 1'b0, -1};
        tbl[5] = '{2, 8'h28, 1'b1, -1};
        tbl[6] = '{1, 8'hFF, 1'b1, -1};
        checks = 0;
        errors = 0;
        rst = 1'b1;
        hit_vld = '0;
        out_rdy = 1'b1;
        enc_data = 8'h00;
        mcnt = 16'h0;
        prev_ack = '0;
        prev_sel_n = '1;
        ack_seen = '0;
        for (int i = 0; i < NCH; i++) fine_tab[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sel_n", 32'(enc_sel_n), 32'hF);
        chk("rst_hit_ack", 32'(hit_ack), 0);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;

        // all four channels in one cycle, straight after reset
        for (int i = 0; i < NCH; i++) fine_tab[i] = 8'h11 + 8'(i);
        ack_seen = '0;
        for (int i = 0; i < NCH; i++) sbq.push_back(mkw(i, fine_tab[i], 1'b0, mcnt));
        hit_vld = '1;
        wait_acks(4'hF, 60, "all4_served");
        tick();
        tick();

        for (int i = 0; i < 7; i++) run_one(tbl[i]);

        // backpressure in OUT
        out_rdy = 1'b0;
        fine_tab[1] = 8'h22;
        ack_seen = '0;
        sbq.push_back(mkw(1, 8'h22, 1'b0, mcnt));
        hit_vld[1] = 1'b1;
        n = 0;
        while (!out_vld && n < 20) begin
            tick();
            n++;
        end
        chk("bp_out_vld", 32'(out_vld), 1);
        held = out_data;
        repeat (10) begin
            tick();
            chk("bp_vld_hold", 32'(out_vld), 1);
            chk("bp_data_hold", out_data, held);
            chk("bp_no_ack", 32'(hit_ack), 0);
        end
        out_rdy = 1'b1;
        wait_acks(4'h2, 5, "bp_ack_after_rdy");
        tick();
        tick();

        // reset during CAPT
        fine_tab[3] = 8'h09;
        ack_seen = '0;
        hit_vld[3] = 1'b1;
        n = 0;
        while (enc_sel_n[3] && n < 10) begin
            tick();
            n++;
        end
        tick();
        chk("capt_sel_n", 32'(enc_sel_n), 32'h7);
        rst = 1'b1;
        mcnt = 16'h0;
        #1;
        chk("rst_async_sel_n", 32'(enc_sel_n), 32'hF);
        chk("rst_async_out_vld", 32'(out_vld), 0);
        tick();
        tick();
        chk("rst_no_ack", 32'(ack_seen), 0);
        rst = 1'b0;
        sbq.push_back(mkw(3, 8'h09, 1'b0, 16'h0000));
        wait_acks(4'h8, 20, "rst_reserved");
        tick();
        tick();

        // coarse counter wrap
        fine_tab[0] = 8'h05;
        fine_tab[1] = 8'h06;
        wait_cnt(16'hFFFF);
        ack_seen = '0;
        sbq.push_back(mkw(0, 8'h05, 1'b0, 16'hFFFF));
        hit_vld[0] = 1'b1;
        tick();
        sbq.push_back(mkw(1, 8'h06, 1'b0, 16'h0000));
        hit_vld[1] = 1'b1;
        wait_acks(4'h3, 40, "wrap_served");
        tick();
        tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdc_readout_sched.md
TDC_READOUT_SCHED -- requirements
Module: tdc_readout_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of encoder channels sharing one readout bus (2..8).
REQ-002 SHALL have parameter CW, default 16, coarse counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port hit_vld, input, NCH, per-channel flag: thermometer latch frozen and valid, held high until acknowledged.
REQ-006 SHALL have port hit_ack, output, NCH, one-cycle pulse clearing the granted channel's latch.
REQ-007 SHALL have port enc_sel_n, output, NCH, active-low encoder output enables onto the shared tri-state bus.
REQ-008 SHALL have port enc_data, input, 8, shared encoder bus carrying fine code 0x00..0x27.
REQ-009 SHALL have port out_vld, output, 1, event word valid.
REQ-010 SHALL have port out_rdy, input, 1, downstream accepts the word.
REQ-011 SHALL have port out_data, output, 32, event word.

Function
REQ-012 SHALL run a free-running CW-bit coarse counter, +1 per cycle, wrapping all-ones -> 0.
REQ-013 SHALL capture the coarse counter into a per-channel stamp register on the cycle a rising edge of hit_vld[i] is seen; no recapture while hit_vld[i] stays high.
REQ-014 SHALL use FSM states IDLE, SEL, CAPT, OUT, ACK.
REQ-015 IDLE: if any hit_vld set, grant one channel by round-robin -> SEL; else stay.
REQ-016 Round-robin: search starts at the channel after the last granted one, wrapping NCH-1 -> 0; after reset, search starts at channel 0.
REQ-017 SEL: drive enc_sel_n[grant] low for bus settle -> CAPT.
REQ-018 CAPT: keep enc_sel_n[grant] low, register enc_data -> OUT.
REQ-019 OUT: out_vld high, out_data stable; on out_vld & out_rdy -> ACK; hold otherwise (no timeout).
REQ-020 ACK: hit_ack[grant] pulses high for exactly one cycle, all enc_sel_n high -> IDLE.
REQ-021 enc_sel_n SHALL have at most one bit low, and it SHALL be low only in SEL/CAPT; all bits are high for at least one cycle between grants (no bus contention).
REQ-022 Latency: request seen in IDLE at edge t -> out_vld high after edge t+3; minimum 5 cycles per event with out_rdy held high.
REQ-023 out_data SHALL be formed as [31:24] fine code, [23] err, [22:16] channel index zero-extended, [15:0] stamp (CW>16: low 16 bits; CW<16: zero-extended).
REQ-024 err SHALL be 1 when the fine code is 0x00 (no transition) or greater than 0x27; the word is still emitted.
REQ-025 A channel whose hit_vld rises while another channel is being served SHALL keep its stamp and be served in a later round.
REQ-026 A hit_vld bit that drops before its grant SHALL be ignored; a bit that drops after the grant does not abort the sequence.
REQ-027 out_rdy high outside OUT SHALL have no effect.

Reset
REQ-028 On rst, asynchronously: FSM = IDLE, enc_sel_n all ones, hit_ack = 0, out_vld = 0, out_data = 0, coarse counter = 0, stamps = 0, RR pointer = NCH-1.
REQ-029 Reset asserted mid-sequence SHALL abandon the event with no hit_ack; the pending channel is served again after reset if hit_vld is still high.
REQ-030 hit_vld edge detection history SHALL reset to 0, so a channel high during reset release is stamped on the first cycle after reset.

Structure
REQ-031 Shared package tdc_pkg SHALL hold the FSM state enum, the FINE_MAX = 8'h27 constant, and the out_data field positions.
REQ-032 Round-robin grant logic SHALL be a separate sub-module rr_arbiter (request vector, last-grant pointer, grant index and valid).

Verification
REQ-033 Single hit: channel 2 rises at coarse 0x0100, enc_data 0x13, out_rdy = 1 -> out_data 0x13_02_0100 (err = 0), hit_ack[2] a single pulse, 5 cycles total.
REQ-034 All four channels rise in the same cycle -> served in order 0, 1, 2, 3 with identical stamps; enc_sel_n never has two bits low and has an all-high gap between grants.
REQ-035 Backpressure: out_rdy low for 10 cycles in OUT -> out_vld and out_data held stable; ACK only after out_rdy rises.
REQ-036 enc_data 0x00, and separately 0x30 -> err = 1, word emitted; coarse counter wrap 0xFFFF -> 0x0000 stamps correctly.
REQ-037 rst asserted in CAPT -> enc_sel_n all ones and out_vld 0 immediately; after release the same channel is re-served, with its stamp recaptured.
